// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : FIFO-buffered UART transmitter. Parity support is built only when
//            the macro UART_TX_PARITY_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int MAX_BITS   = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic [MAX_BITS-1:0]           wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic [31:0]                   cycles_per_bit,
  input  logic [3:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  output logic                          uart_txd,
  output logic                          busy,
  output logic                          tx_done
);

  localparam int              c_aw       = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_depth    = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [3:0]      c_max_bits = 4'(MAX_BITS);
  localparam logic [3:0]      c_min_bits = 4'd5;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
  } state_t;
`endif

  state_t                r_state;
  state_t                w_state_nxt;

  logic [MAX_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]       r_wr_ptr;
  logic [c_aw-1:0]       r_rd_ptr;
  logic [c_aw:0]         r_count;
  logic                  r_overflow;

  logic [MAX_BITS-1:0]   r_shift;
  logic [3:0]            r_nbits;
  logic                  r_stop2;
  logic [31:0]           r_cpb;
  logic [31:0]           r_cyc_cnt;
  logic [3:0]            r_bit_cnt;
  logic                  r_txd;

  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [3:0]            w_nbits;
  logic [MAX_BITS-1:0]   w_mask;
  logic [MAX_BITS-1:0]   w_head;
  logic                  w_bit_end;
  logic                  w_txd_nxt;
  logic                  w_cyc_clr;
  logic                  w_bit_inc;
  logic                  w_bit_clr;
  logic                  w_shift_en;
  logic                  w_done;

`ifdef UART_TX_PARITY_EN
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  w_par_en;
  logic                  w_par_bit;
`else
  logic                  w_unused_parity;
  assign w_unused_parity = ^parity_mode;
`endif

  assign w_empty    = (r_count == '0);
  assign full       = (r_count == c_depth);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign w_push     = wr_en & ~full;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_bit_end  = (r_cyc_cnt == r_cpb);
  assign uart_txd   = r_txd;
  assign busy       = ~w_empty | (r_state != S_IDLE);
  assign tx_done    = w_done;

  always_comb begin
    w_nbits = data_bits;
    if (data_bits < c_min_bits) begin
      w_nbits = c_min_bits;
    end else if (data_bits > c_max_bits) begin
      w_nbits = c_max_bits;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      w_mask[i] = (4'(i) < w_nbits);
    end
  end

`ifdef UART_TX_PARITY_EN
  assign w_par_en  = (parity_mode == 2'd1) | (parity_mode == 2'd2);
  assign w_par_bit = (^(w_head & w_mask)) ^ (parity_mode == 2'd2);
`endif

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en && full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_txd_nxt   = r_txd;
    w_cyc_clr   = 1'b0;
    w_bit_inc   = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (!w_empty) begin
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
          w_cyc_clr   = 1'b1;
          w_bit_clr   = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_txd_nxt   = r_shift[0];
          w_cyc_clr   = 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cyc_clr = 1'b1;
          if (r_bit_cnt == r_nbits - 4'd1) begin
            w_bit_clr   = 1'b1;
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_txd_nxt   = r_par_bit;
            end
`endif
          end else begin
            w_bit_inc  = 1'b1;
            w_shift_en = 1'b1;
            w_txd_nxt  = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_txd_nxt   = 1'b1;
          w_cyc_clr   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        w_txd_nxt = 1'b1;
        if (w_bit_end) begin
          w_cyc_clr = 1'b1;
          // bit_cnt distinguishes the first of two stop bits
          if (r_stop2 && (r_bit_cnt == 4'd0)) begin
            w_bit_inc = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_txd     <= 1'b1;
      r_cyc_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_nbits   <= c_min_bits;
      r_stop2   <= 1'b0;
      r_cpb     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_txd   <= w_txd_nxt;
      if (w_cyc_clr || (r_state == S_IDLE)) begin
        r_cyc_cnt <= '0;
      end else begin
        r_cyc_cnt <= r_cyc_cnt + 32'd1;
      end
      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      // frame settings are frozen at the pop so mid-frame input changes are ignored
      if (w_pop) begin
        r_shift <= w_head & w_mask;
        r_nbits <= w_nbits;
        r_stop2 <= stop2;
        r_cpb   <= cycles_per_bit;
      end else if (w_shift_en) begin
        r_shift <= {1'b0, r_shift[MAX_BITS-1:1]};
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_pop) begin
      r_par_en  <= w_par_en;
      r_par_bit <= w_par_bit;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Scoreboard bench for uart_tx_fifo; frames are decoded on uart_txd
//            and compared bit by bit against a queue of expected frames.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int MAX_BITS   = 9;
  localparam int FIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic [8:0]  wr_data = '0;
  logic        full;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [31:0] cycles_per_bit = 32'd3;
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity_mode = 2'd0;
  logic        stop2 = 1'b0;
  logic        uart_txd;
  logic        busy;
  logic        tx_done;

  uart_tx_fifo #(
    .MAX_BITS   (MAX_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .full           (full),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .cycles_per_bit (cycles_per_bit),
    .data_bits      (data_bits),
    .parity_mode    (parity_mode),
    .stop2          (stop2),
    .uart_txd       (uart_txd),
    .busy           (busy),
    .tx_done        (tx_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  typedef struct {
    logic [8:0] data;
    int         nbits;
    logic       par_en;
    logic       par_bit;
    logic       stop2;
    int         cpb;
  } exp_t;

  exp_t exp_q[$];

  bit mon_en         = 1'b0;
  int frames_started = 0;
  int frames_done    = 0;
  int gap_cnt        = 0;
  int max_gap        = 0;
  logic busy_after   = 1'b1;

  // Reference model of a frame from the current settings.
  function automatic exp_t model(input logic [8:0] d);
    exp_t e;
    int   nb;
    logic p;
    nb = int'(data_bits);
    if (nb < 5) nb = 5;
    if (nb > MAX_BITS) nb = MAX_BITS;
    p = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    e.data  = d;
    e.nbits = nb;
`ifdef UART_TX_PARITY_EN
    e.par_en  = (parity_mode == 2'd1) || (parity_mode == 2'd2);
    e.par_bit = p ^ (parity_mode == 2'd2);
`else
    e.par_en  = 1'b0;
    e.par_bit = p;
`endif
    e.stop2 = stop2;
    e.cpb   = int'(cycles_per_bit);
    return e;
  endfunction

  task automatic wr(input logic [8:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(model(d));
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_frame();
    exp_t e;
    logic lv [16];
    int   nlv;
    int   hits;
    int   done_cnt;
    logic done_last;
    bit   ab;
    int   k;
    if (gap_cnt > max_gap) max_gap = gap_cnt;
    gap_cnt = 0;
    frames_started++;
    check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) begin
      k = 0;
      while (uart_txd === 1'b0 && k < 2000) begin
        @(negedge clk);
        k++;
      end
      return;
    end
    e   = exp_q.pop_front();
    nlv = 0;
    lv[nlv++] = 1'b0;
    for (int i = 0; i < e.nbits; i++) lv[nlv++] = e.data[i];
    if (e.par_en) lv[nlv++] = e.par_bit;
    lv[nlv++] = 1'b1;
    if (e.stop2) lv[nlv++] = 1'b1;
    ab        = 1'b0;
    done_cnt  = 0;
    done_last = 1'b0;
    for (int b = 0; b < nlv && !ab; b++) begin
      hits = 0;
      for (int c = 0; c <= e.cpb && !ab; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!mon_en) begin
          ab = 1'b1;
        end else begin
          if (uart_txd === lv[b]) hits++;
          if (tx_done === 1'b1) done_cnt++;
          if (b == nlv - 1 && c == e.cpb) done_last = tx_done;
        end
      end
      if (!ab) check($sformatf("frame%0d_bit%0d", frames_started, b), 32'(hits), 32'(e.cpb + 1));
    end
    if (ab) return;
    check($sformatf("frame%0d_tx_done_cnt", frames_started), 32'(done_cnt), 32'd1);
    check($sformatf("frame%0d_tx_done_last", frames_started), {31'd0, done_last}, 32'd1);
    @(negedge clk);
    busy_after = busy;
    if (mon_en) begin
      check($sformatf("frame%0d_idle_txd", frames_started), {31'd0, uart_txd}, 32'd1);
      gap_cnt = 1;
    end
    frames_done++;
  endtask

  always begin
    @(negedge clk);
    if (!mon_en) begin
      gap_cnt = 0;
    end else if (uart_txd === 1'b0) begin
      run_frame();
    end else begin
      gap_cnt++;
    end
  end

  task automatic wait_done(input int target, input int limit);
    int k = 0;
    while (frames_done < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("frames_done_in_time", 32'(frames_done), 32'(target));
  endtask

  task automatic wait_start(input int target, input int limit);
    int k = 0;
    while (frames_started < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("frame_start_in_time", 32'(frames_started), 32'(target));
  endtask

  initial begin
    int base;
    int lows;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single 8N1 frame, four cycles per bit
    cycles_per_bit = 32'd3;
    data_bits      = 4'd8;
    parity_mode    = 2'd0;
    stop2          = 1'b0;
    base = frames_done;
    wr(9'h055, 1'b1);
    wait_done(base + 1, 300);
    check("busy_after_single", {31'd0, busy_after}, 32'd0);

    // Parity (odd) with 7 data bits and two stop bits
    cycles_per_bit = 32'd1;
    data_bits      = 4'd7;
    parity_mode    = 2'd2;
    stop2          = 1'b1;
    base = frames_done;
    wr(9'h003, 1'b1);
    wait_done(base + 1, 300);
    parity_mode = 2'd0;
    stop2       = 1'b0;

    // Fill the FIFO and overflow it
    cycles_per_bit = 32'd100;
    data_bits      = 4'd5;
    base = frames_done;
    for (int i = 0; i < 17; i++) wr(9'(i * 3 + 1), 1'b1);
    check("full_after_17", {31'd0, full}, 32'd1);
    check("count_after_17", {27'd0, fifo_count}, 32'd16);
    check("no_overflow_17", {31'd0, overflow}, 32'd0);
    wr(9'h1AA, 1'b0);
    check("overflow_after_18", {31'd0, overflow}, 32'd1);
    check("count_after_18", {27'd0, fifo_count}, 32'd16);
    wait_done(base + 17, 14000);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    check("count_drained", {27'd0, fifo_count}, 32'd0);

    // Back-to-back frames
    cycles_per_bit = 32'd2;
    data_bits      = 4'd8;
    base = frames_done;
    wr(9'h0A5, 1'b1);
    wr(9'h03C, 1'b1);
    wr(9'h0FF, 1'b1);
    wait_start(frames_started + 1, 50);
    max_gap = 0;
    wait_done(base + 3, 400);
    check("b2b_gap_le_1", 32'(max_gap <= 1), 32'd1);
    check("b2b_count_zero", {27'd0, fifo_count}, 32'd0);

    // Reset in the middle of a frame with two entries queued
    cycles_per_bit = 32'd3;
    wr(9'h00F, 1'b1);
    wr(9'h0F0, 1'b1);
    wr(9'h033, 1'b1);
    wait_start(frames_started + 1, 50);
    repeat (15) @(negedge clk);
    mon_en = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_txd", {31'd0, uart_txd}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_count", {27'd0, fifo_count}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    resetn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("no_frames_after_reset", 32'(lows), 32'd0);

    // data_bits clamp and mid-frame setting change
    cycles_per_bit = 32'd1;
    data_bits      = 4'd2;
    base = frames_done;
    wr(9'h01F, 1'b1);
    wait_start(frames_started + 1, 50);
    data_bits = 4'd8;
    wr(9'h0C3, 1'b1);
    wait_done(base + 2, 200);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter MAX_BITS, default 9, maximum payload bits per frame (legal range 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries (power of two, minimum 2).
REQ-003 SHALL use clock clk; reset resetn is synchronous and active-low.
REQ-004 SHALL have ports:
- clk, input, 1: system clock.
- resetn, input, 1: synchronous active-low reset.
- wr_en, input, 1: push wr_data into the FIFO.
- wr_data, input, MAX_BITS: frame payload, LSB sent first.
- full, output, 1: FIFO holds FIFO_DEPTH entries.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- overflow, output, 1: sticky flag, a write was dropped.
- cycles_per_bit, input, 32: bit period minus one, in clk cycles.
- data_bits, input, 4: payload bits per frame.
- parity_mode, input, 2: 0 = none, 1 = even, 2 = odd, 3 = none.
- stop2, input, 1: 1 selects two stop bits.
- uart_txd, output, 1: serial line, registered.
- busy, output, 1: FIFO non-empty or FSM not IDLE.
- tx_done, output, 1: one-cycle pulse at the end of the last stop bit.

Function
REQ-005 SHALL accept a write when wr_en=1 and full=0; a write with full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-006 SHALL update fifo_count by +1 on write only, -1 on pop only, and leave it unchanged on a simultaneous write and pop; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-007 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-008 FSM transitions:
- IDLE -> START when the FIFO is non-empty; the head entry is popped and latched that cycle.
- START -> DATA.
- DATA -> PARITY when parity is enabled, otherwise DATA -> STOP.
- PARITY -> STOP.
- STOP -> IDLE.
REQ-009 SHALL sample data_bits, parity_mode, stop2 and cycles_per_bit at the pop; input changes mid-frame SHALL NOT affect the frame in progress.
REQ-010 Every bit SHALL last exactly cycles_per_bit+1 clk cycles; cycles_per_bit=0 gives one cycle per bit.
REQ-011 SHALL clamp data_bits: values below 5 are used as 5, values above MAX_BITS are used as MAX_BITS.
REQ-012 DATA SHALL send the latched payload bits 0..data_bits-1, LSB first; bits at or above data_bits are ignored.
REQ-013 The parity bit SHALL be the XOR of the sent payload bits (even) or its inverse (odd).
REQ-014 STOP SHALL drive 1 for one bit period, or two when stop2=1.
REQ-015 uart_txd SHALL be 1 in IDLE and SHALL go low the clock after the pop, i.e. one cycle after the IDLE -> START decision.
REQ-016 tx_done SHALL pulse for one cycle on the STOP -> IDLE transition.
REQ-017 When the FIFO is non-empty at STOP -> IDLE, the next frame SHALL pop on the following cycle; at most one idle cycle separates frames.
REQ-018 A frame of 8N1 with cycles_per_bit=N SHALL occupy exactly 10*(N+1) cycles of uart_txd low/data/high, from the START edge to the end of the stop bit.

Reset
REQ-019 When resetn=0 at a clk edge, the block SHALL set:
- uart_txd=1, busy=0, full=0, fifo_count=0, overflow=0, tx_done=0.
- FSM = IDLE, bit and cycle counters = 0.
- FIFO emptied.
REQ-020 Reset asserted mid-frame SHALL abort the frame; uart_txd SHALL read 1 on the cycle after the reset edge, and all FIFO contents are discarded.

Configuration
REQ-021 With macro UART_TX_PARITY_EN defined, the PARITY state and parity_mode decoding SHALL be present as specified in REQ-013.
REQ-022 Without UART_TX_PARITY_EN, parity_mode SHALL be ignored, the PARITY state and its logic SHALL be absent, and DATA SHALL always go to STOP.

Verification
REQ-023 Single frame:
- Stimulus: cycles_per_bit=3, data_bits=8, parity 0, stop2=0; write 0x55.
- Response: txd low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; tx_done pulses once; busy drops the cycle after.
REQ-024 Parity and two stop bits (UART_TX_PARITY_EN defined):
- Stimulus: data_bits=7, parity_mode=2, stop2=1; write 0x03.
- Response: 7 data bits 1,1,0,0,0,0,0, parity bit 1, two stop bit periods.
REQ-025 Full FIFO and overflow:
- Stimulus: cycles_per_bit=100; write 17 entries back-to-back with FIFO_DEPTH=16.
- Response: the first write pops immediately, so full asserts at the 17th write and no overflow occurs; an 18th write sets overflow and fifo_count stays 16.
REQ-026 Back-to-back frames:
- Stimulus: write 0xA5, 0x3C, 0xFF.
- Response: three frames with at most one idle cycle between them, three tx_done pulses, fifo_count reaches 0.
REQ-027 Reset mid-frame:
- Stimulus: resetn=0 during bit 3 of a frame, with 2 entries queued.
- Response: next cycle txd=1, busy=0, fifo_count=0; no further frames are sent.
REQ-028 Clamp and mid-frame config change:
- Stimulus: data_bits=2; write 0x1F, then change data_bits to 8 mid-frame.
- Response: the frame carries 5 data bits, all 1; the next frame uses 8.
